// File: rtl/lolap_sponge_ctrl_if.sv
// Handshake and permutation bus between the LolaP sponge controller and its environment.
// Purely signal grouping; no storage, no latency.
// Backpressure: in_ready_o/in_valid_i on the absorb side, out_valid_o/out_ready_i on the squeeze side.
interface lolap_sponge_ctrl_if;
  logic [31:0]  in_data_i;
  logic         in_valid_i;
  logic         in_last_i;
  logic         in_ready_o;
  logic [256:0] perm_state_o;
  logic [256:0] perm_state_i;
  logic [31:0]  out_data_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic         busy_o;

  // Controller side
  modport slave (
    input  in_data_i, in_valid_i, in_last_i, perm_state_i, out_ready_i,
    output in_ready_o, perm_state_o, out_data_o, out_valid_o, busy_o
  );

  // Producer / consumer / round-block side
  modport master (
    output in_data_i, in_valid_i, in_last_i, perm_state_i, out_ready_i,
    input  in_ready_o, perm_state_o, out_data_o, out_valid_o, busy_o
  );
endinterface

// File: rtl/lolap_sponge_ctrl.sv
// Sponge controller: absorbs 32-bit words into a 257-bit state, iterates the external LolaP round, squeezes a digest.
// Latency: last word accepted at cycle T, first digest word valid at T+1+NUM_ROUNDS (another NUM_ROUNDS if a pad block is pending).
// Backpressure: in_ready_o only in ABSORB; digest word held stable while out_ready_i is low. Optional macro LOLAP_SPONGE_PAD_EN adds 10*1 word padding.
module lolap_sponge_ctrl #(
  parameter int RATE_WORDS = 4,
  parameter int NUM_ROUNDS = 12,
  parameter int OUT_WORDS  = 8
) (
  input logic                 clk,
  input logic                 rst,
  lolap_sponge_ctrl_if.slave  bus
);

  localparam int WC_W = 4;
  localparam int RC_W = (NUM_ROUNDS < 2) ? 1 : $clog2(NUM_ROUNDS + 1);
  localparam int OC_W = (OUT_WORDS < 2) ? 1 : $clog2(OUT_WORDS + 1);

  typedef enum logic [1:0] {
    ABSORB  = 2'd0,
    PERMUTE = 2'd1,
    SQUEEZE = 2'd2
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [256:0]     state_q, state_d;
  logic [WC_W-1:0]  wc_q, wc_d;
  logic [RC_W-1:0]  round_q, round_d;
  logic [WC_W-1:0]  sc_q, sc_d;
  logic [OC_W-1:0]  oc_q, oc_d;
  logic             last_q, last_d;
  logic             squeezing_q, squeezing_d;
`ifdef LOLAP_SPONGE_PAD_EN
  logic             pad_pending_q, pad_pending_d;
`endif

  logic             in_ready;
  logic             out_valid;
  logic             busy;
  logic [31:0]      out_data;

  // State register and all control flops; reset aborts any message in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q         <= ABSORB;
      state_q       <= '0;
      wc_q          <= '0;
      round_q       <= '0;
      sc_q          <= '0;
      oc_q          <= '0;
      last_q        <= 1'b0;
      squeezing_q   <= 1'b0;
`ifdef LOLAP_SPONGE_PAD_EN
      pad_pending_q <= 1'b0;
`endif
    end else begin
      fsm_q         <= fsm_d;
      state_q       <= state_d;
      wc_q          <= wc_d;
      round_q       <= round_d;
      sc_q          <= sc_d;
      oc_q          <= oc_d;
      last_q        <= last_d;
      squeezing_q   <= squeezing_d;
`ifdef LOLAP_SPONGE_PAD_EN
      pad_pending_q <= pad_pending_d;
`endif
    end
  end

  // Next-state, datapath and handshake outputs for the absorb/permute/squeeze sequence.
  always_comb begin
    fsm_d         = fsm_q;
    state_d       = state_q;
    wc_d          = wc_q;
    round_d       = round_q;
    sc_d          = sc_q;
    oc_d          = oc_q;
    last_d        = last_q;
    squeezing_d   = squeezing_q;
`ifdef LOLAP_SPONGE_PAD_EN
    pad_pending_d = pad_pending_q;
`endif
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    busy          = 1'b0;
    out_data      = '0;

    case (fsm_q)
      ABSORB: begin
        in_ready = 1'b1;
        if (bus.in_valid_i) begin
          // Only rate words are touched; capacity and bit 256 stay under permutation control.
          state_d[32*wc_q +: 32] = state_q[32*wc_q +: 32] ^ bus.in_data_i;
          wc_d   = wc_q + WC_W'(1);
          last_d = bus.in_last_i;
`ifdef LOLAP_SPONGE_PAD_EN
          if (bus.in_last_i) begin
            if (wc_q != WC_W'(RATE_WORDS - 1)) begin
              // Pad fits in this block; coinciding positions naturally yield 0x80000001.
              state_d[32*(wc_q + WC_W'(1)) +: 32] = state_d[32*(wc_q + WC_W'(1)) +: 32] ^ 32'h0000_0001;
              state_d[32*(RATE_WORDS-1) +: 32]    = state_d[32*(RATE_WORDS-1) +: 32] ^ 32'h8000_0000;
            end else begin
              // Message filled the block: the pad goes into an extra block after this permutation.
              pad_pending_d = 1'b1;
            end
          end
`endif
          if (wc_q == WC_W'(RATE_WORDS - 1) || bus.in_last_i) begin
            fsm_d   = PERMUTE;
            round_d = '0;
          end
        end
      end

      PERMUTE: begin
        busy    = 1'b1;
        state_d = bus.perm_state_i;
        round_d = round_q + RC_W'(1);
        if (round_q == RC_W'(NUM_ROUNDS - 1)) begin
          round_d = '0;
`ifdef LOLAP_SPONGE_PAD_EN
          if (pad_pending_q) begin
            // Pad block is absorbed on top of the last round result, then permuted again.
            state_d[31:0]                    = state_d[31:0] ^ 32'h0000_0001;
            state_d[32*(RATE_WORDS-1) +: 32] = state_d[32*(RATE_WORDS-1) +: 32] ^ 32'h8000_0000;
            pad_pending_d                    = 1'b0;
          end else
`endif
          if (last_q || squeezing_q) begin
            fsm_d = SQUEEZE;
            sc_d  = '0;
          end else begin
            fsm_d = ABSORB;
            wc_d  = '0;
          end
        end
      end

      SQUEEZE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = state_q[32*sc_q +: 32];
        if (bus.out_ready_i) begin
          sc_d = sc_q + WC_W'(1);
          oc_d = oc_q + OC_W'(1);
          if (oc_q == OC_W'(OUT_WORDS - 1)) begin
            // Digest complete: wipe everything so the next message starts from a zero state.
            fsm_d       = ABSORB;
            state_d     = '0;
            wc_d        = '0;
            round_d     = '0;
            sc_d        = '0;
            oc_d        = '0;
            last_d      = 1'b0;
            squeezing_d = 1'b0;
          end else if (sc_q == WC_W'(RATE_WORDS - 1)) begin
            squeezing_d = 1'b1;
            fsm_d       = PERMUTE;
            round_d     = '0;
          end
        end
      end

      default: begin
        fsm_d = ABSORB;
      end
    endcase
  end

  assign bus.in_ready_o   = in_ready;
  assign bus.out_valid_o  = out_valid;
  assign bus.busy_o       = busy;
  assign bus.out_data_o   = out_data;
  assign bus.perm_state_o = state_q;

endmodule
